// File: rtl/native2apb_bridge.sv
// native2apb_bridge: single-beat native peripheral request -> APB3 initiator.
// IDLE captures the request, SETUP/ACCESS run the APB phases (honouring pready),
// RESP returns a one-cycle nat_ready with nat_err/nat_rdata.
// Optional build macro APB_TIMEOUT_EN adds an ACCESS wait-state timeout that
// aborts with nat_err after TIMEOUT_CYCLES cycles of pready low.
module native2apb_bridge #(
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              nat_sel,
   input  logic              nat_write,
   input  logic [ADDR_W-1:0] nat_addr,
   input  logic [DATA_W-1:0] nat_wdata,
   output logic [DATA_W-1:0] nat_rdata,
   output logic              nat_ready,
   output logic              nat_err,
   output logic              apb_psel,
   output logic              apb_penable,
   output logic              apb_pwrite,
   output logic [ADDR_W-1:0] apb_paddr,
   output logic [DATA_W-1:0] apb_pwdata,
   input  logic [DATA_W-1:0] apb_prdata,
   input  logic              apb_pready,
   input  logic              apb_pslverr
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic                abort_s;

   logic [DATA_W-1:0]   nat_rdata_r,  nat_rdata_d_s;
   logic                nat_ready_r,  nat_ready_d_s;
   logic                nat_err_r,    nat_err_d_s;
   logic                psel_r,       psel_d_s;
   logic                penable_r,    penable_d_s;
   logic                pwrite_r,     pwrite_d_s;
   logic [ADDR_W-1:0]   paddr_r,      paddr_d_s;
   logic [DATA_W-1:0]   pwdata_r,     pwdata_d_s;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt_r;

   // Count ACCESS cycles spent with pready low; cleared while in SETUP so it
   // starts from zero on every entry to ACCESS.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt_r <= '0;
      end else if (state_r == ST_SETUP) begin
         wait_cnt_r <= '0;
      end else if ((state_r == ST_ACCESS) && !apb_pready) begin
         wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // This low-pready cycle is the one that brings the count to the limit.
   assign abort_s = (state_r == ST_ACCESS) && !apb_pready &&
                    (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign abort_s = 1'b0;
`endif

   // State and output registers; reset clears everything and aborts any transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         nat_rdata_r <= '0;
         nat_ready_r <= 1'b0;
         nat_err_r   <= 1'b0;
         psel_r      <= 1'b0;
         penable_r   <= 1'b0;
         pwrite_r    <= 1'b0;
         paddr_r     <= '0;
         pwdata_r    <= '0;
      end else begin
         state_r     <= state_nxt_s;
         nat_rdata_r <= nat_rdata_d_s;
         nat_ready_r <= nat_ready_d_s;
         nat_err_r   <= nat_err_d_s;
         psel_r      <= psel_d_s;
         penable_r   <= penable_d_s;
         pwrite_r    <= pwrite_d_s;
         paddr_r     <= paddr_d_s;
         pwdata_r    <= pwdata_d_s;
      end
   end

   // Next-state logic; nat_sel is only looked at in IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (nat_sel) begin
               state_nxt_s = ST_SETUP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_nxt_s = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (apb_pready || abort_s) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_ACCESS;
            end
         end
         ST_RESP: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output next values, derived from the upcoming state so every output is a flop.
   always_comb begin
      psel_d_s      = (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
      penable_d_s   = (state_nxt_s == ST_ACCESS);
      nat_ready_d_s = (state_nxt_s == ST_RESP);
      nat_err_d_s   = 1'b0;
      nat_rdata_d_s = nat_rdata_r;
      pwrite_d_s    = pwrite_r;
      paddr_d_s     = paddr_r;
      pwdata_d_s    = pwdata_r;
      if ((state_r == ST_IDLE) && nat_sel) begin
         pwrite_d_s = nat_write;
         paddr_d_s  = nat_addr;
         pwdata_d_s = nat_wdata;
      end else begin
         pwrite_d_s = pwrite_r;
      end
      if ((state_r == ST_ACCESS) && (apb_pready || abort_s)) begin
         // A pready in the limit cycle is a normal completion, not a timeout.
         if (apb_pready) begin
            nat_err_d_s = apb_pslverr;
         end else begin
            nat_err_d_s = 1'b1;
         end
         if (!pwrite_r) begin
            if (apb_pready && !apb_pslverr) begin
               nat_rdata_d_s = apb_prdata;
            end else begin
               nat_rdata_d_s = '0;
            end
         end else begin
            nat_rdata_d_s = nat_rdata_r;
         end
      end else begin
         nat_err_d_s = 1'b0;
      end
   end

   assign nat_rdata   = nat_rdata_r;
   assign nat_ready   = nat_ready_r;
   assign nat_err     = nat_err_r;
   assign apb_psel    = psel_r;
   assign apb_penable = penable_r;
   assign apb_pwrite  = pwrite_r;
   assign apb_paddr   = paddr_r;
   assign apb_pwdata  = pwdata_r;

endmodule

// File: tb/tb_native2apb_bridge.sv
// Testbench for native2apb_bridge: directed scenarios plus randomized transfers
// checked against a transaction-level model (latency, error, read data).
module tb_native2apb_bridge;

`ifdef APB_TIMEOUT_EN
   localparam int TMO   = 4;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TMO   = 255;
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        nat_sel;
   logic        nat_write;
   logic [15:0] nat_addr;
   logic [31:0] nat_wdata;
   logic [31:0] nat_rdata;
   logic        nat_ready;
   logic        nat_err;
   logic        apb_psel;
   logic        apb_penable;
   logic        apb_pwrite;
   logic [15:0] apb_paddr;
   logic [31:0] apb_pwdata;
   logic [31:0] apb_prdata;
   logic        apb_pready;
   logic        apb_pslverr;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_rdata = 32'h0;

   native2apb_bridge #(
      .ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .nat_sel(nat_sel), .nat_write(nat_write), .nat_addr(nat_addr),
      .nat_wdata(nat_wdata), .nat_rdata(nat_rdata), .nat_ready(nat_ready),
      .nat_err(nat_err), .apb_psel(apb_psel), .apb_penable(apb_penable),
      .apb_pwrite(apb_pwrite), .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata),
      .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
   );

   always #5 clk = ~clk;

   // One transfer from its first sampling edge to the RESP cycle. Starts at a
   // negedge with the bridge idle and returns at the negedge of the RESP cycle.
   // waits = ACCESS cycles with pready low before the slave answers.
   task automatic run_xfer(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                           input int waits, input logic serr, input logic [31:0] rd);
      int   lat;
      bit   abort;
      bit   done;
      logic exp_err;
      logic [31:0] exp_rd_next;
      nat_sel = 1'b1; nat_write = wr; nat_addr = a; nat_wdata = wd;
      apb_pready = 1'b0; apb_pslverr = 1'b0;
      abort = TO_EN && (waits >= TMO);
      lat   = abort ? (TMO + 2) : (waits + 3);
      exp_err = abort ? 1'b1 : serr;
      if (wr) exp_rd_next = exp_rdata;
      else if (abort || serr) exp_rd_next = 32'h0;
      else exp_rd_next = rd;
      done = 1'b0;
      @(posedge clk);
      for (int c = 1; c <= lat + 2 && !done; c++) begin
         @(negedge clk);
         if (c == 1) begin
            nat_addr = 16'($urandom); nat_wdata = $urandom; nat_write = ~wr;
         end
         if (nat_ready) begin
            checks++;
            if (c != lat) begin
               failures++; $display("FAIL latency: got %0d cycles, expected %0d", c, lat);
            end
            checks++;
            if (nat_err !== exp_err) begin
               failures++; $display("FAIL nat_err: got %b, expected %b", nat_err, exp_err);
            end
            checks++;
            if (nat_rdata !== exp_rd_next) begin
               failures++; $display("FAIL nat_rdata: got %h, expected %h", nat_rdata, exp_rd_next);
            end
            checks++;
            if (apb_psel !== 1'b0 || apb_penable !== 1'b0) begin
               failures++; $display("FAIL resp_apb_idle: got psel=%b penable=%b, expected 0 0", apb_psel, apb_penable);
            end
            exp_rdata = exp_rd_next;
            done = 1'b1;
         end else begin
            checks++;
            if (apb_psel !== 1'b1 || apb_penable !== (c >= 2) || apb_paddr !== a ||
                apb_pwdata !== wd || apb_pwrite !== wr || nat_err !== 1'b0) begin
               failures++;
               $display("FAIL apb_phase c=%0d: got psel=%b pen=%b addr=%h wdata=%h wr=%b err=%b, expected 1 %b %h %h %b 0",
                        c, apb_psel, apb_penable, apb_paddr, apb_pwdata, apb_pwrite, nat_err, (c >= 2), a, wd, wr);
            end
            if (c >= 2) begin
               if (c - 1 > waits) begin
                  apb_pready = 1'b1; apb_pslverr = serr; apb_prdata = rd;
               end else begin
                  apb_pready = 1'b0; apb_pslverr = 1'($urandom); apb_prdata = $urandom;
               end
            end
         end
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL no_ready: got no nat_ready within %0d cycles, expected at %0d", lat + 2, lat);
      end
      apb_pready = 1'b0; apb_pslverr = 1'b0;
   endtask

   // Transfer followed by the one idle cycle after RESP; keep=1 leaves nat_sel
   // high through RESP (back-to-back), which must not start a transfer in RESP.
   task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                       input int waits, input logic serr, input logic [31:0] rd, input bit keep);
      run_xfer(wr, a, wd, waits, serr, rd);
      if (!keep) nat_sel = 1'b0;
      @(negedge clk);
      checks++;
      if (apb_psel !== 1'b0 || apb_penable !== 1'b0 || nat_ready !== 1'b0 ||
          nat_err !== 1'b0 || nat_rdata !== exp_rdata) begin
         failures++;
         $display("FAIL idle_gap: got psel=%b pen=%b ready=%b err=%b rdata=%h, expected 0 0 0 0 %h",
                  apb_psel, apb_penable, nat_ready, nat_err, nat_rdata, exp_rdata);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; nat_sel = 1'b0; nat_write = 1'b0; nat_addr = 16'h0; nat_wdata = 32'h0;
      apb_prdata = 32'h0; apb_pready = 1'b0; apb_pslverr = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({nat_rdata, nat_ready, nat_err, apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata} !== 84'h0) begin
         failures++;
         $display("FAIL reset_state: got rdata=%h ready=%b err=%b psel=%b pen=%b wr=%b addr=%h wdata=%h, expected all 0",
                  nat_rdata, nat_ready, nat_err, apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata);
      end
      exp_rdata = 32'h0;
   endtask

   task automatic test_zero_wait_write();
      xfer(1'b1, 16'h0010, 32'hCAFE_F00D, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
   endtask

   task automatic test_read_wait();
      xfer(1'b0, 16'h0020, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0);
   endtask

   task automatic test_read_slverr();
      xfer(1'b0, 16'h0030, 32'h0, 1, 1'b1, 32'hFFFF_FFFF, 1'b0);
   endtask

   task automatic test_back_to_back();
      xfer(1'b0, 16'h0040, 32'h0, 0, 1'b0, 32'hA5A5_0001, 1'b1);
      xfer(1'b1, 16'h0044, 32'h5A5A_0002, 0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_reset_abort();
      xfer(1'b0, 16'h0050, 32'h0, 0, 1'b0, 32'h0BAD_CAFE, 1'b0);
      nat_sel = 1'b1; nat_write = 1'b0; nat_addr = 16'h0054; apb_pready = 1'b0;
      @(posedge clk);
      @(negedge clk);            // SETUP
      @(negedge clk);            // ACCESS, first wait cycle
      @(negedge clk);            // ACCESS, second wait cycle
      rst_n = 1'b0; nat_sel = 1'b0;
      @(negedge clk);
      checks++;
      if ({nat_rdata, nat_ready, nat_err, apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata} !== 84'h0) begin
         failures++;
         $display("FAIL reset_abort: got rdata=%h ready=%b err=%b psel=%b pen=%b addr=%h, expected all 0",
                  nat_rdata, nat_ready, nat_err, apb_psel, apb_penable, apb_paddr);
      end
      rst_n = 1'b1; apb_pready = 1'b1;
      exp_rdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (nat_ready !== 1'b0 || apb_psel !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_quiet: got ready=%b psel=%b, expected 0 0", nat_ready, apb_psel);
         end
      end
      apb_pready = 1'b0;
   endtask

   task automatic test_timeout();
      if (TO_EN) begin
         xfer(1'b0, 16'h0060, 32'h0, 50, 1'b0, 32'h7777_7777, 1'b0);
         xfer(1'b0, 16'h0064, 32'h0, TMO - 1, 1'b0, 32'h1357_9BDF, 1'b0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         xfer(1'($urandom), 16'($urandom), $urandom, $urandom_range(0, TO_EN ? 6 : 5),
              ($urandom_range(0, 3) == 0), $urandom, 1'($urandom));
      end
      nat_sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_zero_wait_write();
      test_read_wait();
      test_read_slverr();
      test_back_to_back();
      test_reset_abort();
      test_timeout();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/native2apb_bridge.md
# native2apb_bridge

APB initiator that turns single-beat requests on the team's native peripheral port (sel/write/addr/wdata/rdata) into APB3 transfers. It is the master-side counterpart of the native-to-APB-slave wrappers used for peripherals such as tbman. It sits between the CPU data-port decoder and the APB peripheral fabric. It adds SETUP/ACCESS sequencing, honours `pready` wait states, and reports `pslverr` (and, optionally, a timeout) back to the native requester.

## Interface
- `ADDR_W`, default 16: native and APB address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT_CYCLES`, default 255: maximum ACCESS cycles with `pready` low before abort. Used only when `APB_TIMEOUT_EN` is defined; minimum value 1.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `nat_sel` in 1: request valid, high active. Held with the request fields until the `nat_ready` cycle.
- `nat_write` in 1: 1 = write, 0 = read.
- `nat_addr` in ADDR_W: request address.
- `nat_wdata` in DATA_W: write data.
- `nat_rdata` out DATA_W: read data, registered.
- `nat_ready` out 1: one-cycle completion pulse.
- `nat_err` out 1: error flag, valid only while `nat_ready` is high.
- `apb_psel` out 1: APB select.
- `apb_penable` out 1: APB enable.
- `apb_pwrite` out 1: APB direction.
- `apb_paddr` out ADDR_W: APB address.
- `apb_pwdata` out DATA_W: APB write data.
- `apb_prdata` in DATA_W: APB read data.
- `apb_pready` in 1: slave ready.
- `apb_pslverr` in 1: slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE: when `nat_sel`=1, capture `nat_write`/`nat_addr`/`nat_wdata` into `apb_pwrite`/`apb_paddr`/`apb_pwdata`, then go to SETUP.
- SETUP: `psel`=1, `penable`=0. Go to ACCESS unconditionally.
- ACCESS: `psel`=1, `penable`=1.
  - `pready`=0: stay in ACCESS.
  - `pready`=1: go to RESP.
  - On a read without `pslverr`, `nat_rdata` ← `prdata`. On a read with `pslverr`, `nat_rdata` ← 0. On a write, `nat_rdata` is unchanged.
  - `nat_err` ← `pslverr`.
- RESP: `psel`=`penable`=0, `nat_ready`=1 for exactly this cycle. `nat_sel` is ignored in RESP. Go to IDLE.
- `apb_pwrite`/`apb_paddr`/`apb_pwdata` are stable from SETUP through the end of ACCESS and hold their last values while idle.
- Native-side changes to request fields between capture and `nat_ready` have no effect.
- `nat_err` is 0 whenever `nat_ready`=0.

## Timing
- Reset (`rst_n`=0 at a `clk` edge): state = IDLE and all outputs = 0 after that edge, including `nat_rdata`. Reset aborts any in-flight transfer mid-SETUP or mid-ACCESS. `psel` drops at the same edge and no `nat_ready` is issued.
- Zero-wait transfer, with `nat_sel` first sampled high at edge 0:
  - SETUP in cycle 1.
  - ACCESS in cycle 2.
  - `nat_ready` in cycle 3.
  - The next request can be accepted in cycle 4.
  - Minimum transfer period is 4 cycles.
- Each cycle of `pready`=0 in ACCESS adds one cycle of latency.
- Back-to-back operation: if `nat_sel` is high in the cycle after RESP, that is a new request. A requester that does not want a second transfer drops `nat_sel` in the RESP cycle.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - A wait counter resets to 0 on entry to ACCESS and increments each ACCESS cycle with `pready`=0.
  - If the counter reaches `TIMEOUT_CYCLES` while `pready`=0, the bridge aborts: next state is RESP, `nat_err`=1, and `nat_rdata` ← 0 on reads.
  - `pready` arriving in the same cycle the counter hits the limit wins: this is a normal completion.
- `APB_TIMEOUT_EN` undefined: no counter is built, and ACCESS waits indefinitely for `pready`.

## Test plan
- Zero-wait write: `addr`=0x0010, `wdata`=0xCAFE_F00D → SETUP then ACCESS with `paddr`/`pwdata` stable; `nat_ready` 3 cycles after `sel`; `nat_err`=0; `nat_rdata` unchanged.
- Read with 3 wait states: `prdata`=0x1234_5678 → `nat_ready` 6 cycles after `sel`; `nat_rdata`=0x1234_5678.
- Read with `pslverr`=1 and `prdata`=0xFFFF_FFFF → `nat_err`=1 and `nat_rdata`=0 in the RESP cycle.
- `nat_sel` held high continuously for two requests → two distinct APB transfers exactly 4 cycles apart (zero wait); no duplicate transfer during RESP.
- `rst_n`=0 in the second ACCESS wait cycle → `psel`/`penable`=0 and all outputs 0 after that edge; no `nat_ready`.
- With `APB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, `pready` stuck low → RESP after 4 ACCESS cycles with `nat_err`=1. Rerun with `pready` rising on the 4th ACCESS cycle → normal completion.
